// File: rtl/vga_sync_gen.sv
// VGA sync and test-pattern generator.
// Two-stage datapath: stage p0 holds the raster counters and the latched
// pattern configuration; stage p1 holds the registered VGA outputs, which
// show the decode of the p0 counters one pixel tick later.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        pix_en,
    input  logic        cfg_enable,
    input  logic [1:0]  cfg_mode,
    input  logic [11:0] cfg_fg,
    input  logic [11:0] cfg_bg,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_de,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter thresholds, sized to the 10-bit raster counters.
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Eight equal-width colour bars across the visible line.
    localparam logic [9:0] BAR_W  = 10'(H_ACTIVE / 8);

    // Pattern colour for a visible pixel; blanking is handled by the caller.
    function automatic logic [11:0] pattern_rgb(
        input logic [1:0]  mode,
        input logic [11:0] fg,
        input logic [11:0] bg,
        input logic [9:0]  x,
        input logic        y5
    );
        logic [9:0]  bar;
        logic [11:0] colour;
        bar    = x / BAR_W;
        colour = bg;
        case (mode)
            2'd1: begin
                case (bar)
                    10'd0:   colour = 12'hFFF;
                    10'd1:   colour = 12'hFF0;
                    10'd2:   colour = 12'h0FF;
                    10'd3:   colour = 12'h0F0;
                    10'd4:   colour = 12'hF0F;
                    10'd5:   colour = 12'hF00;
                    10'd6:   colour = 12'h00F;
                    default: colour = 12'h000;
                endcase
            end
            2'd2:    colour = (x[5] ^ y5) ? fg : bg;
            default: colour = bg;
        endcase
        return colour;
    endfunction

    logic [9:0]  h_cnt_p0;
    logic [9:0]  v_cnt_p0;
    logic [1:0]  mode_p0;
    logic [11:0] fg_p0;
    logic [11:0] bg_p0;

    logic        h_last_p0;
    logic        v_last_p0;
    logic        frame_end_p0;
    logic        hs_d_p0;
    logic        vs_d_p0;
    logic        vld_d_p0;
    logic        fs_d_p0;
    logic [11:0] rgb_d_p0;

    logic        hs_p1;
    logic        vs_p1;
    logic        vld_p1;
    logic        fs_p1;
    logic [11:0] rgb_p1;
    logic [9:0]  x_p1;
    logic [9:0]  y_p1;

    // Decode the current counters into the values the output stage will load.
    always_comb begin
        h_last_p0    = (h_cnt_p0 == H_LAST);
        v_last_p0    = (v_cnt_p0 == V_LAST);
        frame_end_p0 = h_last_p0 && v_last_p0;
        vld_d_p0     = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
        hs_d_p0      = !((h_cnt_p0 >= HS_BEG) && (h_cnt_p0 < HS_END));
        vs_d_p0      = !((v_cnt_p0 >= VS_BEG) && (v_cnt_p0 < VS_END));
        fs_d_p0      = (h_cnt_p0 == 10'd0) && (v_cnt_p0 == 10'd0);
        rgb_d_p0     = 12'h000;
        if (vld_d_p0) begin
            rgb_d_p0 = pattern_rgb(mode_p0, fg_p0, bg_p0, h_cnt_p0, v_cnt_p0[5]);
        end
    end

    // ---- stage p0: raster counters, advanced once per pixel tick ----
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            h_cnt_p0 <= 10'd0;
            v_cnt_p0 <= 10'd0;
        end else if (!cfg_enable) begin
            h_cnt_p0 <= 10'd0;
            v_cnt_p0 <= 10'd0;
        end else if (pix_en) begin
            if (h_last_p0) begin
                h_cnt_p0 <= 10'd0;
                v_cnt_p0 <= v_last_p0 ? 10'd0 : v_cnt_p0 + 10'd1;
            end else begin
                h_cnt_p0 <= h_cnt_p0 + 10'd1;
            end
        end
    end

    // Latch pattern config only between frames (or freely while timing is off).
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            mode_p0 <= 2'd0;
            fg_p0   <= 12'h000;
            bg_p0   <= 12'h000;
        end else if (!cfg_enable || (pix_en && frame_end_p0)) begin
            mode_p0 <= cfg_mode;
            fg_p0   <= cfg_fg;
            bg_p0   <= cfg_bg;
        end
    end

    // ---- stage p1: registered VGA outputs, one pixel tick behind p0 ----
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            vld_p1 <= 1'b0;
            fs_p1  <= 1'b0;
            rgb_p1 <= 12'h000;
            x_p1   <= 10'd0;
            y_p1   <= 10'd0;
        end else if (!cfg_enable) begin
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            vld_p1 <= 1'b0;
            fs_p1  <= 1'b0;
            rgb_p1 <= 12'h000;
            x_p1   <= 10'd0;
            y_p1   <= 10'd0;
        end else if (pix_en) begin
            hs_p1  <= hs_d_p0;
            vs_p1  <= vs_d_p0;
            vld_p1 <= vld_d_p0;
            fs_p1  <= fs_d_p0;
            rgb_p1 <= rgb_d_p0;
            x_p1   <= h_cnt_p0;
            y_p1   <= v_cnt_p0;
        end else begin
            // Everything else holds; the frame marker must stay one clock wide.
            fs_p1  <= 1'b0;
        end
    end

    assign vga_hs      = hs_p1;
    assign vga_vs      = vs_p1;
    assign vga_de      = vld_p1;
    assign frame_start = fs_p1;
    assign vga_r       = rgb_p1[11:8];
    assign vga_g       = rgb_p1[7:4];
    assign vga_b       = rgb_p1[3:0];
    assign pix_x       = x_p1;
    assign pix_y       = y_p1;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full-width horizontal timing with a
// shortened vertical frame (38 lines) to keep the run short.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    localparam int V_ACTIVE = 34;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int LIMIT    = 40000;

    // Packed {hs, vs, de, frame_start} encodings.
    localparam logic [31:0] CTL_IDLE  = 32'hC;
    localparam logic [31:0] CTL_FIRST = 32'hF;
    localparam logic [31:0] CTL_ACT   = 32'hE;

    logic        tb_ACLK = 1'b0;
    logic        aresetn;
    logic        pix_en;
    logic        cfg_enable;
    logic [1:0]  cfg_mode;
    logic [11:0] cfg_fg;
    logic [11:0] cfg_bg;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_de;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    bit toggle  = 1'b0;
    int n;

    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    vga_sync_gen #(
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) dut (
        .ACLK        (tb_ACLK),
        .ARESETN     (aresetn),
        .pix_en      (pix_en),
        .cfg_enable  (cfg_enable),
        .cfg_mode    (cfg_mode),
        .cfg_fg      (cfg_fg),
        .cfg_bg      (cfg_bg),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_de      (vga_de),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
        if (toggle) pix_en = ~pix_en;
    endtask

    function logic [31:0] rgb();
        return 32'({vga_r, vga_g, vga_b});
    endfunction

    function logic [31:0] ctl();
        return 32'({vga_hs, vga_vs, vga_de, frame_start});
    endfunction

    function logic [31:0] pos();
        return 32'({pix_x, pix_y});
    endfunction

    function logic sel(input int which);
        case (which)
            0:       return vga_hs;
            1:       return vga_vs;
            2:       return frame_start;
            default: return vga_de;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ticks until the selected output reaches level; -1 if the bound expires.
    task automatic wait_for(input int which, input logic level, output int cnt);
        cnt = 0;
        while (sel(which) !== level && cnt < LIMIT) begin
            tick();
            cnt++;
        end
        if (sel(which) !== level) cnt = -1;
    endtask

    initial begin
        aresetn    = 1'b0;
        pix_en     = 1'b1;
        cfg_enable = 1'b0;
        cfg_mode   = 2'd0;
        cfg_fg     = 12'h000;
        cfg_bg     = 12'h123;
        repeat (3) tick();
        check("reset_ctl", ctl(), CTL_IDLE);
        check("reset_rgb", rgb(), 32'h0);
        check("reset_pos", pos(), 32'h0);

        aresetn = 1'b1;
        tick();
        check("disabled_ctl", ctl(), CTL_IDLE);

        cfg_enable = 1'b1;
        tick();
        check("first_ctl", ctl(), CTL_FIRST);
        check("first_rgb", rgb(), 32'h123);
        check("first_pos", pos(), 32'h0);
        tick();
        check("second_ctl", ctl(), CTL_ACT);
        check("second_pos", pos(), 32'(1 * 1024));

        wait_for(0, 1'b0, n);
        check("hs_fall", 32'(n), 32'd655);
        check("hs_fall_x", 32'(pix_x), 32'd656);
        wait_for(0, 1'b1, n);
        check("hs_low_width", 32'(n), 32'd96);
        wait_for(0, 1'b0, n);
        check("hs_high_width", 32'(n), 32'd704);

        // Change background mid-frame; must not show until the next frame.
        cfg_bg = 12'hFFF;
        wait_for(3, 1'b1, n);
        check("line2_start", 32'(n), 32'd144);
        check("line2_pos", pos(), 32'(2));
        check("line2_rgb_held", rgb(), 32'h123);

        wait_for(1, 1'b0, n);
        check("vs_fall", 32'(n), 32'd26400);
        check("vs_fall_y", 32'(pix_y), 32'd35);
        check("vs_blank_rgb", rgb(), 32'h0);
        wait_for(1, 1'b1, n);
        check("vs_low_width", 32'(n), 32'd1600);
        wait_for(2, 1'b1, n);
        check("vs_to_frame", 32'(n), 32'd800);
        check("frame2_ctl", ctl(), CTL_FIRST);
        check("frame2_rgb", rgb(), 32'hFFF);
        check("frame2_pos", pos(), 32'h0);
        tick();
        check("frame2_fs_width", ctl(), CTL_ACT);

        // Disabling forces idle on the next edge even without a pixel tick.
        cfg_enable = 1'b0;
        pix_en     = 1'b0;
        tick();
        check("dis_noen_ctl", ctl(), CTL_IDLE);
        check("dis_noen_pos", pos(), 32'h0);
        check("dis_noen_rgb", rgb(), 32'h0);

        cfg_mode = 2'd1;
        tick();
        cfg_enable = 1'b1;
        pix_en     = 1'b1;
        tick();
        check("bars_first_ctl", ctl(), CTL_FIRST);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            check($sformatf("bar%0d_left", k), rgb(), 32'(bar_tab[k]));
            repeat (79) tick();
            check($sformatf("bar%0d_right", k), rgb(), 32'(bar_tab[k]));
        end
        check("bars_x639_pos", pos(), 32'(639 * 1024));
        check("bars_x639_ctl", ctl(), CTL_ACT);
        tick();
        check("bars_x640_ctl", ctl(), CTL_IDLE);
        check("bars_x640_rgb", rgb(), 32'h0);
        check("bars_x640_pos", pos(), 32'(640 * 1024));

        cfg_enable = 1'b0;
        cfg_mode   = 2'd2;
        cfg_fg     = 12'hF00;
        cfg_bg     = 12'h00F;
        tick();
        cfg_enable = 1'b1;
        tick();
        check("chk_0_0", rgb(), 32'h00F);
        repeat (32) tick();
        check("chk_32_0", rgb(), 32'hF00);
        repeat (800 * 32 - 32) tick();
        check("chk_0_32_pos", pos(), 32'(32));
        check("chk_0_32", rgb(), 32'hF00);
        repeat (32) tick();
        check("chk_32_32", rgb(), 32'h00F);

        // Pixel tick every other clock.
        cfg_enable = 1'b0;
        tick();
        cfg_enable = 1'b1;
        pix_en     = 1'b1;
        toggle     = 1'b1;
        tick();
        check("half_first_ctl", ctl(), CTL_FIRST);
        tick();
        check("half_fs_width", ctl(), CTL_ACT);
        check("half_hold_pos", pos(), 32'h0);
        wait_for(0, 1'b0, n);
        check("half_hs_fall", 32'(n), 32'd1311);
        wait_for(0, 1'b1, n);
        check("half_hs_low", 32'(n), 32'd192);
        wait_for(0, 1'b0, n);
        check("half_hs_high", 32'(n), 32'd1408);

        // Asynchronous reset while hs is low.
        toggle = 1'b0;
        pix_en = 1'b1;
        check("pre_reset_ctl", ctl(), 32'h4);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_reset_ctl", ctl(), CTL_IDLE);
        check("async_reset_pos", pos(), 32'h0);
        check("async_reset_rgb", rgb(), 32'h0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        check("post_reset_ctl", ctl(), CTL_FIRST);
        check("post_reset_pos", pos(), 32'h0);
        check("post_reset_rgb", rgb(), 32'h0);
        tick();
        check("post_reset_next", pos(), 32'(1 * 1024));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
